segled_status_driver: RTL and testbench
=======================================

Name: segled_status_driver

Overview:
- Downstream consumer of the game top's status registers: `score`, `health` and the `game` state code.
- Renders them on the board's 8-digit serial seven-segment display, driving the SEGLED_Clk / SEGLED_CLR / SEGLED_DO / SEGLED_PEN pins, which are currently unused.
- Periodically snapshots the inputs, encodes 8 digit bytes, shifts 64 bits out through the on-board shift-register chain, then enables the display.

Parameters:
- CLK_HALF, 4: `clk` cycles per half period of `seg_clk`. Legal range is 1 or more.
- REFRESH_DIV, 1_000_000: `clk` cycles between automatic frame starts (10 ms at 100 MHz). Legal range is 2 or more.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- score  in  32  game score; only [23:0] is displayed
- health  in  4  remaining health
- game_state  in  2  00 begin, 01 playing, 11 win, 10 lose
- force_update  in  1  1-cycle pulse; request a frame immediately
- seg_clk  out  1  serial clock to the display chain
- seg_clr  out  1  active-low chain clear
- seg_do  out  1  serial data, MSB first
- seg_pen  out  1  display enable; 1 = show latched data
- busy  out  1  frame in progress

Behaviour:
- Reset values: `seg_clk`=0, `seg_clr`=0, `seg_do`=0, `seg_pen`=0, `busy`=0. Refresh counter=0, pending flag=0, FSM=CLEAR.
- Reset asserted mid-frame aborts the frame immediately, and all outputs take their reset values on the next edge.
- FSM states:
  - CLEAR: `seg_clr`=0 for 2*CLK_HALF cycles, then go to IDLE with `seg_clr`=1. `seg_clr` stays 1 until the next reset.
  - IDLE: a start occurs when the refresh counter reaches REFRESH_DIV-1, or `force_update`=1, or pending=1. On start, go to LOAD.
  - LOAD: 1 cycle. Snapshot the inputs and build a 64-bit frame. `busy`=1 from LOAD until the return to IDLE.
  - SHIFT: 64 bit periods of 2*CLK_HALF cycles each.
    - `seg_do` is updated in the cycle `seg_clk` falls (and at SHIFT entry, with `seg_clk`=0).
    - `seg_clk` is high for the second half of each period, so data is stable on every rising edge.
    - `seg_pen`=0 throughout SHIFT.
  - LATCH: `seg_clk`=0 and `seg_pen` goes to 1 for the cycle after the 64th rising edge. Then return to IDLE; `seg_pen` holds 1.
- Refresh counter:
  - Free-running mod REFRESH_DIV; it is not reset by `force_update`.
  - A start request (tick or `force_update`) arriving while `busy`=1 sets pending; pending clears at LOAD.
  - Multiple requests while busy collapse into one.
- Frame layout: digit 7 is shifted first, bit7 of each byte first. Byte format is active-low {dp,g,f,e,d,c,b,a}, so 0 = segment lit.
  - digit7 = blank (0xFF)
  - digit6 = hex(`health`)
  - digits5..0 = hex(`score[23:0]`), no leading-zero suppression
- Glyphs:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
- Game-state overrides, applied at LOAD:
  - game_state=00: all 8 bytes 0xFF.
  - game_state=10: dp lit (bit7 cleared) on every digit.
  - game_state=11: dp lit on digit7 only.
  - game_state=01: no override.
- Latency from start to `seg_pen` rising = 1 (LOAD) + 128*CLK_HALF + 1 cycles.
- Inputs that change during SHIFT do not affect the current frame.

Optional Feature:
- Macro: SEGLED_BCD_EN.
- Defined:
  - `score` is clamped to 999999 when above it.
  - An added CONVERT state between LOAD and SHIFT performs sequential double-dabble, one bit per cycle for 24 cycles, producing 6 BCD digits.
  - Digits5..0 show decimal (glyphs 0-9 only).
  - Latency increases by 24 cycles.
  - `busy` stays 1 during CONVERT.
- Undefined: hex display as above; no CONVERT state.

Test Plan:
- Reset then release with CLK_HALF=4:
  - `seg_clr`=0 for 8 cycles, then 1.
  - `seg_pen`=0 and `busy`=0 until the first tick.
- game_state=01, health=5, score=0x00001A, `force_update` pulse:
  - 64 rising edges of `seg_clk` capture FF 92 C0 C0 C0 C0 F9 88.
  - `seg_pen` rises 1+128*4+1 = 514 cycles after LOAD.
- game_state=00 with any values: captured frame is eight 0xFF; game_state=10, health=3, score=0: captured frame is 7F 30 40 40 40 40 40 40.
- `force_update` pulsed 3 times mid-SHIFT: exactly one extra frame follows immediately after LATCH; assert reset at bit 20 of that frame: all outputs return to reset values next cycle, and no LATCH occurs.
- SEGLED_BCD_EN defined, score=1234567, health=2:
  - Frame is FF A4 90 90 90 90 90 90 (clamped to 999999).
  - `busy` duration is 24 cycles longer than in the hex build.

Source files
------------

// File: rtl/segled_status_driver_if.sv
`default_nettype none
// ============================================================
// segled_status_driver_if: game status inputs and display pins
// Rev 1.0
// ============================================================
interface segled_status_driver_if;
  logic [31:0] score;
  logic [3:0]  health;
  logic [1:0]  game_state;
  logic        force_update;
  logic        seg_clk;
  logic        seg_clr;
  logic        seg_do;
  logic        seg_pen;
  logic        busy;

  // master = status producer (game top), slave = display driver
  modport master (
    output score, health, game_state, force_update,
    input  seg_clk, seg_clr, seg_do, seg_pen, busy
  );

  modport slave (
    input  score, health, game_state, force_update,
    output seg_clk, seg_clr, seg_do, seg_pen, busy
  );
endinterface
`default_nettype wire

// File: rtl/segled_status_driver.sv
`default_nettype none
// ============================================================
// segled_status_driver: renders score/health/state on the serial
// 8-digit seven-segment chain. Option macro: SEGLED_BCD_EN. Rev 1.0
// ============================================================
module segled_status_driver #(
  parameter int CLK_HALF    = 4,
  parameter int REFRESH_DIV = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  segled_status_driver_if.slave sif
);

  localparam int PH_W  = $clog2(2 * CLK_HALF);
  localparam int REF_W = $clog2(REFRESH_DIV);

  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(CLK_HALF - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_HALF - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_LATCH   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_seg_clk;
  logic             r_seg_clr;
  logic             r_seg_do;
  logic             r_seg_pen;
  logic             r_pending;
  logic [PH_W-1:0]  r_ph;
  logic [5:0]       r_bit;
  logic [REF_W-1:0] r_refresh;
  logic [62:0]      r_shreg;

  logic             w_tick;
  logic             w_req;
  logic             w_start;
  logic             w_busy;
  logic             w_ph_last;
  logic             w_last_bit;
  logic [63:0]      w_frame;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    return 8'hC0;
      4'h1:    return 8'hF9;
      4'h2:    return 8'hA4;
      4'h3:    return 8'hB0;
      4'h4:    return 8'h99;
      4'h5:    return 8'h92;
      4'h6:    return 8'h82;
      4'h7:    return 8'hF8;
      4'h8:    return 8'h80;
      4'h9:    return 8'h90;
      4'hA:    return 8'h88;
      4'hB:    return 8'h83;
      4'hC:    return 8'hC6;
      4'hD:    return 8'hA1;
      4'hE:    return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Byte order is digit7..digit0, so the frame MSB is the first bit on the wire.
  function automatic logic [63:0] build_frame(input logic [23:0] digits,
                                              input logic [3:0]  h,
                                              input logic [1:0]  gs);
    logic [63:0] f;
    f = {8'hFF, glyph(h),
         glyph(digits[23:20]), glyph(digits[19:16]), glyph(digits[15:12]),
         glyph(digits[11:8]),  glyph(digits[7:4]),   glyph(digits[3:0])};
    case (gs)
      2'b00: f = '1;
      2'b10: for (int i = 0; i < 8; i++) f[i*8+7] = 1'b0;
      2'b11: f[63] = 1'b0;
      default: ;
    endcase
    return f;
  endfunction

`ifdef SEGLED_BCD_EN
  logic [23:0] r_bin;
  logic [23:0] r_bcd;
  logic [3:0]  r_snap_health;
  logic [1:0]  r_snap_state;
  logic [4:0]  r_conv;
  logic [23:0] w_clamped;
  logic [47:0] w_dd;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift {bcd,bin} left.
  function automatic logic [47:0] dd_step(input logic [23:0] bcd, input logic [23:0] bin);
    logic [23:0] adj;
    for (int i = 0; i < 6; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return {adj[22:0], bin[23], bin[22:0], 1'b0};
  endfunction

  assign w_clamped = (sif.score > 32'd999_999) ? 24'd999_999 : sif.score[23:0];
  assign w_dd      = dd_step(r_bcd, r_bin);
  assign w_frame   = build_frame(w_dd[47:24], r_snap_health, r_snap_state);
`else
  logic w_unused_score_hi;
  assign w_unused_score_hi = ^sif.score[31:24];
  assign w_frame = build_frame(sif.score[23:0], sif.health, sif.game_state);
`endif

  assign w_tick     = (r_refresh == REF_LAST);
  assign w_req      = w_tick | sif.force_update;
  assign w_start    = w_req | r_pending;
  assign w_ph_last  = (r_ph == PH_LAST);
  assign w_last_bit = (r_bit == 6'd63);
  assign w_busy     = (r_state == ST_LOAD) || (r_state == ST_CONVERT) ||
                      (r_state == ST_SHIFT) || (r_state == ST_LATCH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR:   if (w_ph_last) w_next = ST_IDLE;
      ST_IDLE:    if (w_start) w_next = ST_LOAD;
`ifdef SEGLED_BCD_EN
      ST_LOAD:    w_next = ST_CONVERT;
      ST_CONVERT: if (r_conv == 5'd23) w_next = ST_SHIFT;
`else
      ST_LOAD:    w_next = ST_SHIFT;
`endif
      ST_SHIFT:   if (w_ph_last && w_last_bit) w_next = ST_LATCH;
      ST_LATCH:   w_next = ST_IDLE;
      default:    w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_clk <= 1'b0;
      r_seg_clr <= 1'b0;
      r_seg_do  <= 1'b0;
      r_seg_pen <= 1'b0;
      r_pending <= 1'b0;
      r_ph      <= '0;
      r_bit     <= '0;
      r_refresh <= '0;
      r_shreg   <= '0;
`ifdef SEGLED_BCD_EN
      r_bin         <= '0;
      r_bcd         <= '0;
      r_snap_health <= '0;
      r_snap_state  <= '0;
      r_conv        <= '0;
`endif
    end else begin
      r_refresh <= w_tick ? '0 : r_refresh + 1'b1;

      // Requests seen while a frame is in flight collapse into a single pending start.
      if (r_state == ST_IDLE && w_start) r_pending <= 1'b0;
      else if (w_busy && w_req)          r_pending <= 1'b1;

      case (r_state)
        ST_CLEAR: begin
          r_ph <= w_ph_last ? '0 : r_ph + 1'b1;
          if (w_ph_last) r_seg_clr <= 1'b1;
        end
        ST_IDLE: begin
          if (w_start) r_seg_pen <= 1'b0;
        end
        ST_LOAD: begin
`ifdef SEGLED_BCD_EN
          r_bin         <= w_clamped;
          r_bcd         <= '0;
          r_conv        <= '0;
          r_snap_health <= sif.health;
          r_snap_state  <= sif.game_state;
`else
          r_shreg   <= w_frame[62:0];
          r_seg_do  <= w_frame[63];
          r_seg_clk <= 1'b0;
          r_ph      <= '0;
          r_bit     <= '0;
`endif
        end
`ifdef SEGLED_BCD_EN
        ST_CONVERT: begin
          r_bcd  <= w_dd[47:24];
          r_bin  <= w_dd[23:0];
          r_conv <= r_conv + 1'b1;
          if (r_conv == 5'd23) begin
            r_shreg   <= w_frame[62:0];
            r_seg_do  <= w_frame[63];
            r_seg_clk <= 1'b0;
            r_ph      <= '0;
            r_bit     <= '0;
          end
        end
`endif
        ST_SHIFT: begin
          // Clock rises mid-period; data only moves on the falling edge.
          if (r_ph == PH_MID) r_seg_clk <= 1'b1;
          if (w_ph_last) begin
            r_ph      <= '0;
            r_seg_clk <= 1'b0;
            if (!w_last_bit) begin
              r_bit    <= r_bit + 1'b1;
              r_seg_do <= r_shreg[62];
              r_shreg  <= {r_shreg[61:0], 1'b0};
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        ST_LATCH: begin
          r_seg_clk <= 1'b0;
          r_seg_pen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sif.seg_clk = r_seg_clk;
  assign sif.seg_clr = r_seg_clr;
  assign sif.seg_do  = r_seg_do;
  assign sif.seg_pen = r_seg_pen;
  assign sif.busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_segled_status_driver.sv
`default_nettype none
// ============================================================
// tb_segled_status_driver: directed bench with frame scoreboard
// Rev 1.0
// ============================================================
module tb_segled_status_driver;

  localparam int CLK_HALF    = 4;
  localparam int REFRESH_DIV = 8000;
`ifdef SEGLED_BCD_EN
  localparam int LAT = 2 + 128 * CLK_HALF + 24;
`else
  localparam int LAT = 2 + 128 * CLK_HALF;
`endif

  logic clk = 1'b0;
  logic reset;

  segled_status_driver_if sif ();

  segled_status_driver #(
    .CLK_HALF    (CLK_HALF),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total  = 0;
  int          passed = 0;
  int          failed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cap_bits;
  int          cap_got;
  logic        cap_prev;
  int          pen_in_shift;
  int unsigned t_load;
  int unsigned t_prev;

  function automatic logic [7:0] glyph_m(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [63:0] model_frame(input logic [31:0] sc, input logic [3:0] h,
                                              input logic [1:0] gs);
    logic [63:0] f;
    logic [3:0]  d [6];
`ifdef SEGLED_BCD_EN
    int v;
    v = (sc > 32'd999999) ? 999999 : int'(sc);
    for (int k = 0; k < 6; k++) begin
      d[k] = 4'(v % 10);
      v    = v / 10;
    end
`else
    for (int k = 0; k < 6; k++) d[k] = sc[k*4 +: 4];
`endif
    f = {8'hFF, glyph_m(h), glyph_m(d[5]), glyph_m(d[4]), glyph_m(d[3]),
         glyph_m(d[2]), glyph_m(d[1]), glyph_m(d[0])};
    if (gs == 2'b00)      f = {64{1'b1}};
    else if (gs == 2'b10) for (int k = 0; k < 8; k++) f[k*8+7] = 1'b0;
    else if (gs == 2'b11) f[63] = 1'b0;
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [31:0] sc, input logic [3:0] h, input logic [1:0] gs);
    sif.score      = sc;
    sif.health     = h;
    sif.game_state = gs;
  endtask

  task automatic pulse();
    sif.force_update = 1'b1;
    @(negedge clk);
    sif.force_update = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    if (sif.seg_clk === 1'b1 && cap_prev === 1'b0) begin
      cap_bits = {cap_bits[62:0], sif.seg_do};
      cap_got++;
    end
    if (sif.seg_pen !== 1'b0) pen_in_shift++;
    cap_prev = sif.seg_clk;
  endtask

  task automatic pulse_sampled();
    sif.force_update = 1'b1;
    sample();
    sif.force_update = 1'b0;
  endtask

  task automatic start_capture();
    cap_bits     = '0;
    cap_got      = 0;
    cap_prev     = sif.seg_clk;
    pen_in_shift = 0;
  endtask

  task automatic capture(input int n);
    int target;
    int guard;
    target = cap_got + n;
    guard  = 0;
    while (cap_got < target && guard < 1500) begin
      sample();
      guard++;
    end
  endtask

  task automatic wait_busy(input int bound);
    int guard;
    guard = 0;
    while (sif.busy !== 1'b1 && guard < bound) begin
      @(negedge clk);
      guard++;
    end
    t_load = cyc;
  endtask

  task automatic finish_frame(input string tag);
    logic [63:0] e;
    int          guard;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = ~cap_bits;
    check({tag, " data"}, cap_bits, e);
    check({tag, " pen_in_shift"}, 64'(pen_in_shift), 64'd0);
    guard = 0;
    while (sif.seg_pen !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " latency"}, 64'(cyc - t_load), 64'(LAT));
    check({tag, " busy_end"}, 64'(sif.busy), 64'd0);
  endtask

  task automatic simple_frame(input string tag, input logic [31:0] sc, input logic [3:0] h,
                              input logic [1:0] gs);
    set_inputs(sc, h, gs);
    exp_q.push_back(model_frame(sc, h, gs));
    pulse();
    wait_busy(20);
    start_capture();
    capture(64);
    finish_frame(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    reset            = 1'b1;
    sif.force_update = 1'b0;
    set_inputs(32'h0, 4'h0, 2'b00);
    repeat (3) @(negedge clk);
    check("reset_state", 64'({sif.seg_clk, sif.seg_clr, sif.seg_do, sif.seg_pen, sif.busy}),
          64'd0);

    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (sif.seg_clr === 1'b0) n++;
      @(negedge clk);
    end
    check("clr_low_cycles", 64'(n), 64'd8);
    check("clr_high", 64'(sif.seg_clr), 64'd1);

    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.busy !== 1'b0 || sif.seg_pen !== 1'b0) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    // Inputs scrambled after the snapshot must not reach the shifted frame.
    set_inputs(32'h0000_001A, 4'h5, 2'b01);
    exp_q.push_back(model_frame(32'h0000_001A, 4'h5, 2'b01));
    pulse();
    wait_busy(20);
    start_capture();
    capture(2);
    set_inputs(32'hFFFF_FFFF, 4'hF, 2'b00);
    capture(62);
    finish_frame("A_playing");

    simple_frame("B_begin", 32'h0012_3456, 4'h7, 2'b00);
    simple_frame("C_lose", 32'h0000_0000, 4'h3, 2'b10);

    set_inputs(32'h00BC_DEF9, 4'hA, 2'b11);
    exp_q.push_back(model_frame(32'h00BC_DEF9, 4'hA, 2'b11));
    exp_q.push_back(model_frame(32'h00BC_DEF9, 4'hA, 2'b11));
    pulse();
    wait_busy(20);
    start_capture();
    capture(10);
    pulse_sampled();
    capture(10);
    pulse_sampled();
    capture(10);
    pulse_sampled();
    capture(64 - cap_got);
    finish_frame("D_win");
    t_prev = cyc;
    wait_busy(20);
    check("pending_gap", 64'(cyc - t_prev), 64'd1);
    start_capture();
    capture(64);
    finish_frame("E_pending");
    bad = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (sif.busy !== 1'b0) bad++;
    end
    check("collapse_single", 64'(bad), 64'd0);

    set_inputs(32'd1234567, 4'h2, 2'b01);
    exp_q.push_back(model_frame(32'd1234567, 4'h2, 2'b01));
    exp_q.push_back(model_frame(32'd1234567, 4'h2, 2'b01));
    pulse();
    wait_busy(20);
    start_capture();
    capture(5);
    pulse_sampled();
    capture(64 - cap_got);
    finish_frame("F_score");
    t_prev = cyc;
    wait_busy(20);
    check("pending_gap2", 64'(cyc - t_prev), 64'd1);
    start_capture();
    capture(20);
    check("abort_bit_count", 64'(cap_got), 64'd20);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", 64'({sif.seg_clk, sif.seg_clr, sif.seg_do, sif.seg_pen, sif.busy}),
          64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());

    set_inputs(32'h00FE_DC10, 4'h0, 2'b10);
    exp_q.push_back(model_frame(32'h00FE_DC10, 4'h0, 2'b10));
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    t_prev = cyc;
    bad    = 0;
    n      = 0;
    while (sif.busy !== 1'b1 && n < REFRESH_DIV + 200) begin
      @(negedge clk);
      n++;
      if (sif.seg_pen !== 1'b0) bad++;
    end
    t_load = cyc;
    check("no_latch_after_abort", 64'(bad), 64'd0);
    check("tick_period", 64'(t_load - t_prev), 64'(REFRESH_DIV));
    start_capture();
    capture(64);
    finish_frame("H_tick");
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
